// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic family (adder, subtractor).
// Holds the common handshake state encoding and the counter-width helper.
package serial_arith_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  function automatic int calc_cw(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/fsub_bit.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout set on underflow.
module fsub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = a - b (mod 2^WIDTH), LSB first, one bit per clock,
// with the en/IDLE/DONE handshake shared with the serial adder.
module sub_serial
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done
);

  localparam int CW = calc_cw(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    count;
  logic             bit_diff;
  logic             bit_borrow;

  fsub_bit u_fsub_bit (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (borrow),
    .d    (bit_diff),
    .bout (bit_borrow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Encoding 3 is unreachable in normal operation; the default arm returns it to IDLE.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = en ? SUB : IDLE;
      SUB:     state_next = (count == LAST_BIT) ? DONE : SUB;
      DONE:    state_next = en ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done = 1'b0;
    if (state == DONE) begin
      done = 1'b1;
    end
  end

  // Operands are captured only on the start cycle, so a/b changes during SUB are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      count  <= '0;
      out    <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            a_reg  <= a;
            b_reg  <= b;
            count  <= '0;
            out    <= '0;
            borrow <= 1'b0;
          end
        end
        SUB: begin
          borrow <= bit_borrow;
          out    <= {bit_diff, out[WIDTH-1:1]};
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          count  <= count + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
